picorv32_pcpi_div_param: RTL and testbench
==========================================

Name: picorv32_pcpi_div_param

Overview:
Parametrised PCPI divide/remainder coprocessor for the RV M extension. It handles DIV/DIVU/REM/REMU and, when XLEN=64, the optional DIVW/DIVUW/REMW/REMUW. Compared with the first-generation divider it adds configurable XLEN and configurable radix (bits retired per cycle). It also adds single-cycle fast paths for divide-by-zero and signed overflow, plus a one-entry result cache so that a DIV/REM pair on the same operands costs one iteration sequence. It sits on the core's PCPI bus beside the multiplier.

Parameters:
XLEN, 32, datapath width; legal values are 32 or 64.
STEPS, 1, quotient bits retired per cycle; legal values are 1, 2, 4 or 8, and STEPS must divide XLEN.
ENABLE_W, 0, decodes opcode 0111011 (the W ops); legal only when XLEN=64.
ENABLE_CACHE, 1, enables the one-entry operand/result cache.

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
pcpi_valid  in  1  instruction offered; held by the core until pcpi_ready
pcpi_insn  in  32  instruction word
pcpi_rs1  in  XLEN  dividend operand
pcpi_rs2  in  XLEN  divisor operand
pcpi_wr  out  1  write rd this cycle
pcpi_rd  out  XLEN  result
pcpi_wait  out  1  busy, iterating
pcpi_ready  out  1  result valid, single-cycle pulse

Behaviour:
- Reset: asynchronous and active-low. While resetn=0, pcpi_wr=0, pcpi_rd=0, pcpi_wait=0, pcpi_ready=0, the FSM is in IDLE and the cache-valid bit is 0. Reset asserted mid-operation aborts the operation and no ready pulse is produced.
- All outputs are registered.
- Decode match requires all of:
  - pcpi_valid=1 and pcpi_ready=0;
  - funct7=0000001 and funct3[2]=1;
  - opcode=0110011, or opcode=0111011 with ENABLE_W=1.
- funct3 encoding: 100=DIV, 101=DIVU, 110=REM, 111=REMU.
- FSM states are IDLE, RUN and DONE.
- IDLE, on a decode match (cycle 0):
  - latch rs1, rs2, op and the W flag;
  - form absolute values for signed ops;
  - record the quotient and remainder signs: quotient negative iff signs differ and rs2!=0; remainder takes the dividend's sign.
- IDLE, choice of next state:
  - go to DONE at cycle 1 if the divisor is 0, or on signed overflow, or on a cache hit;
  - otherwise go to RUN.
- W operands: use the low 32 bits. Signed W ops sign-extend from bit 31; unsigned W ops zero-extend. The 32-bit result is sign-extended to XLEN.
- RUN:
  - pcpi_wait=1 throughout;
  - each cycle performs STEPS restoring compare/subtract steps, MSB first;
  - after XLEN/STEPS cycles, go to DONE.
  - Normal latency: ready is in cycle XLEN/STEPS+1 after acceptance; wait is high in cycles 1..XLEN/STEPS.
- DONE, for one cycle:
  - pcpi_ready=1, pcpi_wr=1, pcpi_wait=0;
  - pcpi_rd = the signed-corrected quotient or remainder;
  - next state is IDLE.
  - Outside DONE, pcpi_rd=0.
- Divide by zero: quotient = all ones; remainder = rs1 (for W ops, sign-extended low 32 bits). pcpi_wait never asserts.
- Signed overflow (most-negative value ÷ -1, tested at operation width): quotient = dividend; remainder = 0.
- Cache, when ENABLE_CACHE=1:
  - Stored on each completed RUN: {rs1, rs2, signed, W, quotient, remainder}.
  - A hit requires the valid bit set and all of rs1, rs2, signedness and W equal; the op may be either DIV or REM.
  - Fast-path results are not cached.
  - The cache is invalidated only by reset.
- Abort: if pcpi_valid falls during RUN, the block returns to IDLE next cycle with no ready, and the cache is not updated.
- Back-to-back: a new match may be accepted in the cycle after DONE.

Test Plan:
1. XLEN=32, STEPS=1: DIV rs1=0xFFFFFFF9 (-7), rs2=2 -> wait high in cycles 1..32; ready/wr in cycle 33 with rd=0xFFFFFFFD. Then REM on the same operands -> cache hit, ready in cycle 1, rd=0xFFFFFFFF, wait never high.
2. DIVU 0x80000000 ÷ 0 -> ready in cycle 1, rd=0xFFFFFFFF. REMU 0x80000000 ÷ 0 -> rd=0x80000000. No wait assertion in either case.
3. DIV 0x80000000 ÷ 0xFFFFFFFF -> ready in cycle 1, rd=0x80000000. REM with the same operands -> rd=0.
4. DIV 100 ÷ 7 -> rd=14 in cycle 33. REMU 100 ÷ 7 -> cache miss on signedness, full 33 cycles, rd=2. REMU 100 ÷ 7 again -> cycle 1, rd=2.
5. STEPS=4: DIVU 0xFFFFFFFF ÷ 3 -> ready in cycle 9, rd=0x55555555. Separately, deassert resetn at cycle 5 of a DIV -> all outputs 0 immediately, no ready, and the next identical DIV takes the full 9 cycles.
6. XLEN=64, ENABLE_W=1: DIVW rs1=0x00000000_FFFFFFF9, rs2=2 -> rd=0xFFFFFFFF_FFFFFFFD in cycle 65. DIVU 64-bit 2^64-1 ÷ 0x10 -> rd=0x0FFFFFFF_FFFFFFFF. pcpi_valid dropped at cycle 10 of a RUN -> no ready pulse.

Source files
------------

// File: rtl/picorv32_pcpi_div_param_if.sv
// PCPI bus bundle between the core (master) and a coprocessor (slave).
// XLEN must match the coprocessor's XLEN.
interface picorv32_pcpi_div_param_if #(
  parameter int XLEN = 32
);
  logic            pcpi_valid;
  logic [31:0]     pcpi_insn;
  logic [XLEN-1:0] pcpi_rs1;
  logic [XLEN-1:0] pcpi_rs2;
  logic            pcpi_wr;
  logic [XLEN-1:0] pcpi_rd;
  logic            pcpi_wait;
  logic            pcpi_ready;

  modport master (
    output pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2,
    input  pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready
  );

  modport slave (
    input  pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2,
    output pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready
  );
endinterface

// File: rtl/picorv32_pcpi_div_param.sv
// RV M-extension divide/remainder coprocessor on PCPI: configurable width and radix,
// single-cycle divide-by-zero / overflow paths, one-entry operand/result cache.
module picorv32_pcpi_div_param #(
  parameter int XLEN         = 32,
  parameter int STEPS        = 1,
  parameter bit ENABLE_W     = 1'b0,
  parameter bit ENABLE_CACHE = 1'b1
) (
  input logic                        clk,
  input logic                        resetn,
  picorv32_pcpi_div_param_if.slave   pcpi
);
  localparam int ITERS = XLEN / STEPS;
  localparam int CW    = $clog2(ITERS);
  localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;

  function automatic logic [XLEN-1:0] sext32(input logic [XLEN-1:0] v);
    return XLEN'($signed(v[31:0]));
  endfunction

  function automatic logic [XLEN-1:0] fit_w(input logic w, input logic [XLEN-1:0] v);
    return w ? sext32(v) : v;
  endfunction

  // Decode
  logic [6:0] opcode;
  logic       w_in, signed_in, rem_in, match;
  logic       unused_insn;
  assign opcode      = pcpi.pcpi_insn[6:0];
  assign w_in        = ENABLE_W && (XLEN == 64) && (opcode == 7'b0111011);
  assign signed_in   = !pcpi.pcpi_insn[12];
  assign rem_in      = pcpi.pcpi_insn[13];
  assign match       = pcpi.pcpi_valid && !pcpi.pcpi_ready &&
                       (pcpi.pcpi_insn[31:25] == 7'b0000001) && pcpi.pcpi_insn[14] &&
                       ((opcode == 7'b0110011) || w_in);
  assign unused_insn = ^{pcpi.pcpi_insn[24:15], pcpi.pcpi_insn[11:7]};

  // Operands at operation width, extended to XLEN
  logic [XLEN-1:0] rs1_ext, rs2_ext, rs1_abs, rs2_abs;
  logic            rs1_neg, rs2_neg, rs2_zero, ovf;
  always_comb begin
    rs1_ext = pcpi.pcpi_rs1;
    rs2_ext = pcpi.pcpi_rs2;
    if (w_in) begin
      rs1_ext = signed_in ? sext32(pcpi.pcpi_rs1) : XLEN'(pcpi.pcpi_rs1[31:0]);
      rs2_ext = signed_in ? sext32(pcpi.pcpi_rs2) : XLEN'(pcpi.pcpi_rs2[31:0]);
    end
    rs1_neg  = signed_in && rs1_ext[XLEN-1];
    rs2_neg  = signed_in && rs2_ext[XLEN-1];
    rs1_abs  = rs1_neg ? -rs1_ext : rs1_ext;
    rs2_abs  = rs2_neg ? -rs2_ext : rs2_ext;
    rs2_zero = (rs2_ext == '0);
    ovf      = signed_in && (rs2_ext == '1) &&
               (w_in ? (pcpi.pcpi_rs1[31:0] == 32'h8000_0000) : (pcpi.pcpi_rs1 == MIN_VAL));
  end

  // Iteration state
  logic [XLEN-1:0] quo_q, div_q, key_rs1, key_rs2;
  logic [XLEN:0]   rem_q;
  logic [CW-1:0]   cnt;
  logic            q_neg, r_neg, op_rem, op_w, op_signed;

  // Cache
  logic            cache_valid, cache_signed, cache_w;
  logic [XLEN-1:0] cache_rs1, cache_rs2, cache_q, cache_r;
  logic            hit;
  assign hit = ENABLE_CACHE && cache_valid && (cache_rs1 == pcpi.pcpi_rs1) &&
               (cache_rs2 == pcpi.pcpi_rs2) && (cache_signed == signed_in) && (cache_w == w_in);

  // One cycle's worth of restoring steps, MSB first, plus sign/width correction
  logic [XLEN-1:0] quo_v, q_fix, r_fix, run_rd, fast_rd;
  logic [XLEN:0]   rem_v;
  always_comb begin
    // NOTE: blocking assignments chain the STEPS stages within one cycle; each stage
    // reads the value the previous iteration of the loop just produced.
    quo_v = quo_q;
    rem_v = rem_q;
    for (int i = 0; i < STEPS; i++) begin
      rem_v = {rem_v[XLEN-1:0], quo_v[XLEN-1]};
      quo_v = {quo_v[XLEN-2:0], 1'b0};
      if (rem_v >= {1'b0, div_q}) begin
        rem_v    = rem_v - {1'b0, div_q};
        quo_v[0] = 1'b1;
      end
    end
    q_fix  = fit_w(op_w, q_neg ? -quo_v : quo_v);
    r_fix  = fit_w(op_w, r_neg ? -rem_v[XLEN-1:0] : rem_v[XLEN-1:0]);
    run_rd = op_rem ? r_fix : q_fix;

    if (rs2_zero)  fast_rd = rem_in ? fit_w(w_in, rs1_ext) : '1;
    else if (ovf)  fast_rd = rem_in ? '0 : fit_w(w_in, rs1_ext);
    else           fast_rd = rem_in ? cache_r : cache_q;
  end

  // Next state and next registered outputs
  logic            ready_nx, wr_nx, wait_nx, load, step, cache_wr;
  logic [XLEN-1:0] rd_nx;
  always_comb begin
    // NOTE: every output of this block gets a default first so no path infers a latch.
    state_nx = state;
    ready_nx = 1'b0;
    wr_nx    = 1'b0;
    wait_nx  = 1'b0;
    rd_nx    = '0;
    load     = 1'b0;
    step     = 1'b0;
    cache_wr = 1'b0;
    unique case (state)
      IDLE: if (match) begin
        load = 1'b1;
        if (rs2_zero || ovf || hit) begin
          state_nx = DONE;
          ready_nx = 1'b1;
          wr_nx    = 1'b1;
          rd_nx    = fast_rd;
        end else begin
          state_nx = RUN;
          wait_nx  = 1'b1;
        end
      end
      RUN: begin
        if (!pcpi.pcpi_valid) begin
          state_nx = IDLE;
        end else begin
          step = 1'b1;
          if (cnt == '0) begin
            state_nx = DONE;
            ready_nx = 1'b1;
            wr_nx    = 1'b1;
            rd_nx    = run_rd;
            cache_wr = ENABLE_CACHE;
          end else begin
            wait_nx  = 1'b1;
          end
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state           <= IDLE;
      pcpi.pcpi_ready <= 1'b0;
      pcpi.pcpi_wr    <= 1'b0;
      pcpi.pcpi_wait  <= 1'b0;
      pcpi.pcpi_rd    <= '0;
      cache_valid     <= 1'b0;
    end else begin
      state           <= state_nx;
      pcpi.pcpi_ready <= ready_nx;
      pcpi.pcpi_wr    <= wr_nx;
      pcpi.pcpi_wait  <= wait_nx;
      pcpi.pcpi_rd    <= rd_nx;
      if (cache_wr) cache_valid <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      quo_q <= '0; rem_q <= '0; div_q <= '0; cnt <= '0;
      key_rs1 <= '0; key_rs2 <= '0;
      q_neg <= 1'b0; r_neg <= 1'b0; op_rem <= 1'b0; op_w <= 1'b0; op_signed <= 1'b0;
    end else if (load) begin
      quo_q     <= rs1_abs;
      rem_q     <= '0;
      div_q     <= rs2_abs;
      cnt       <= CW'(ITERS - 1);
      key_rs1   <= pcpi.pcpi_rs1;
      key_rs2   <= pcpi.pcpi_rs2;
      q_neg     <= (rs1_neg ^ rs2_neg) && !rs2_zero;
      r_neg     <= rs1_neg;
      op_rem    <= rem_in;
      op_w      <= w_in;
      op_signed <= signed_in;
    end else if (step) begin
      quo_q <= quo_v;
      rem_q <= rem_v;
      cnt   <= cnt - 1'b1;
    end
  end

  // NOTE: the cache payload has no reset; cache_valid alone decides whether it is used.
  always_ff @(posedge clk) begin
    if (cache_wr) begin
      cache_rs1    <= key_rs1;
      cache_rs2    <= key_rs2;
      cache_signed <= op_signed;
      cache_w      <= op_w;
      cache_q      <= q_fix;
      cache_r      <= r_fix;
    end
  end
endmodule

// File: tb/tb_picorv32_pcpi_div_param.sv
// Directed bench for three divider configurations: 32b radix-2, 32b STEPS=4, 64b with W ops.
module tb_picorv32_pcpi_div_param;
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        valid = 1'b0;
  logic [31:0] insn = '0;
  logic [63:0] rs1 = '0, rs2 = '0;
  int          sel = 0;

  logic        o_ready, o_wr, o_wait;
  logic [63:0] o_rd;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  picorv32_pcpi_div_param_if #(.XLEN(32)) if0 ();
  picorv32_pcpi_div_param_if #(.XLEN(32)) if1 ();
  picorv32_pcpi_div_param_if #(.XLEN(64)) if2 ();

  assign if0.pcpi_valid = valid && (sel == 0);
  assign if0.pcpi_insn  = insn;
  assign if0.pcpi_rs1   = rs1[31:0];
  assign if0.pcpi_rs2   = rs2[31:0];
  assign if1.pcpi_valid = valid && (sel == 1);
  assign if1.pcpi_insn  = insn;
  assign if1.pcpi_rs1   = rs1[31:0];
  assign if1.pcpi_rs2   = rs2[31:0];
  assign if2.pcpi_valid = valid && (sel == 2);
  assign if2.pcpi_insn  = insn;
  assign if2.pcpi_rs1   = rs1;
  assign if2.pcpi_rs2   = rs2;

  picorv32_pcpi_div_param #(.XLEN(32), .STEPS(1), .ENABLE_W(1'b0), .ENABLE_CACHE(1'b1))
    dut0 (.clk(clk), .resetn(resetn), .pcpi(if0));
  picorv32_pcpi_div_param #(.XLEN(32), .STEPS(4), .ENABLE_W(1'b0), .ENABLE_CACHE(1'b1))
    dut1 (.clk(clk), .resetn(resetn), .pcpi(if1));
  picorv32_pcpi_div_param #(.XLEN(64), .STEPS(1), .ENABLE_W(1'b1), .ENABLE_CACHE(1'b1))
    dut2 (.clk(clk), .resetn(resetn), .pcpi(if2));

  always_comb begin
    o_ready = 1'b0;
    o_wr    = 1'b0;
    o_wait  = 1'b0;
    o_rd    = '0;
    case (sel)
      0: begin o_ready = if0.pcpi_ready; o_wr = if0.pcpi_wr; o_wait = if0.pcpi_wait; o_rd = {32'b0, if0.pcpi_rd}; end
      1: begin o_ready = if1.pcpi_ready; o_wr = if1.pcpi_wr; o_wait = if1.pcpi_wait; o_rd = {32'b0, if1.pcpi_rd}; end
      default: begin o_ready = if2.pcpi_ready; o_wr = if2.pcpi_wr; o_wait = if2.pcpi_wait; o_rd = if2.pcpi_rd; end
    endcase
  end

  task automatic check(input string name, input int idx, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got 0x%0h, required 0x%0h", name, idx, got, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [2:0] f3, input logic w);
    return {7'b0000001, 5'd2, 5'd1, f3, 5'd3, (w ? 7'b0111011 : 7'b0110011)};
  endfunction

  localparam logic [2:0] F_DIV = 3'b100, F_DIVU = 3'b101, F_REM = 3'b110, F_REMU = 3'b111;

  // Offer one instruction and follow it to its ready pulse (or a cycle budget).
  task automatic run_op(input int s, input logic [31:0] i, input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] exp_rd, input int exp_cyc, input int idx);
    int got_cyc = -1;
    int waits   = 0;
    logic rd_leak = 1'b0;
    @(posedge clk); #1;
    sel = s; insn = i; rs1 = a; rs2 = b; valid = 1'b1;
    for (int c = 1; c <= exp_cyc + 4 && got_cyc < 0; c++) begin
      @(posedge clk); #1;
      if (o_wait) waits++;
      if (o_ready) begin
        got_cyc = c;
        check("rd", idx, o_rd, exp_rd);
        check("wr", idx, 64'(o_wr), 64'd1);
        valid = 1'b0;
      end else if (o_rd != '0) begin
        rd_leak = 1'b1;
      end
    end
    valid = 1'b0;
    check("ready_cycle", idx, 64'(got_cyc), 64'(exp_cyc));
    check("wait_cycles", idx, 64'(waits), 64'(exp_cyc - 1));
    check("rd_outside_done", idx, 64'(rd_leak), 64'd0);
  endtask

  // Watch for a ready pulse that must not happen.
  task automatic expect_silent(input int ncyc, input int idx);
    logic seen = 1'b0;
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clk); #1;
      if (o_ready || o_wr) seen = 1'b1;
    end
    check("no_ready", idx, 64'(seen), 64'd0);
  endtask

  typedef struct {
    int          s;
    logic [31:0] i;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] rd;
    int          cyc;
  } vec_t;

  localparam int NV = 22;
  vec_t vt [NV];

  initial begin
    vt[0]  = '{0, mk(F_DIV, 0),  64'hFFFFFFF9, 64'd2, 64'hFFFFFFFD, 33};
    vt[1]  = '{0, mk(F_REM, 0),  64'hFFFFFFF9, 64'd2, 64'hFFFFFFFF, 1};
    vt[2]  = '{0, mk(F_DIVU, 0), 64'h80000000, 64'd0, 64'hFFFFFFFF, 1};
    vt[3]  = '{0, mk(F_REMU, 0), 64'h80000000, 64'd0, 64'h80000000, 1};
    vt[4]  = '{0, mk(F_DIV, 0),  64'h80000000, 64'hFFFFFFFF, 64'h80000000, 1};
    vt[5]  = '{0, mk(F_REM, 0),  64'h80000000, 64'hFFFFFFFF, 64'h0, 1};
    vt[6]  = '{0, mk(F_DIV, 0),  64'd100, 64'd7, 64'd14, 33};
    vt[7]  = '{0, mk(F_REMU, 0), 64'd100, 64'd7, 64'd2, 33};
    vt[8]  = '{0, mk(F_REMU, 0), 64'd100, 64'd7, 64'd2, 1};
    vt[9]  = '{0, mk(F_DIV, 0),  64'd7, 64'hFFFFFFFD, 64'hFFFFFFFE, 33};
    vt[10] = '{0, mk(F_REM, 0),  64'd7, 64'hFFFFFFFD, 64'd1, 1};
    vt[11] = '{0, mk(F_REM, 0),  64'hFFFFFFF8, 64'd0, 64'hFFFFFFF8, 1};
    vt[12] = '{1, mk(F_DIVU, 0), 64'hFFFFFFFF, 64'd3, 64'h55555555, 9};
    vt[13] = '{1, mk(F_REM, 0),  64'h80000000, 64'd7, 64'hFFFFFFFE, 9};
    vt[14] = '{2, mk(F_DIV, 1),  64'h00000000_FFFFFFF9, 64'd2, 64'hFFFFFFFF_FFFFFFFD, 65};
    vt[15] = '{2, mk(F_DIVU, 0), 64'hFFFFFFFF_FFFFFFFF, 64'h10, 64'h0FFFFFFF_FFFFFFFF, 65};
    vt[16] = '{2, mk(F_REMU, 1), 64'h12345678_FFFFFFFF, 64'h10, 64'hF, 65};
    vt[17] = '{2, mk(F_DIVU, 1), 64'h12345678_FFFFFFFF, 64'h10, 64'h0FFFFFFF, 1};
    vt[18] = '{2, mk(F_DIVU, 0), 64'h12345678_FFFFFFFF, 64'h10, 64'h01234567_8FFFFFFF, 65};
    vt[19] = '{2, mk(F_DIV, 1),  64'h00000000_80000000, 64'h00000000_FFFFFFFF, 64'hFFFFFFFF_80000000, 1};
    vt[20] = '{2, mk(F_REMU, 1), 64'h00000000_80000000, 64'h00000001_00000000, 64'hFFFFFFFF_80000000, 1};
    vt[21] = '{2, mk(F_DIV, 0),  64'h80000000_00000000, 64'hFFFFFFFF_FFFFFFFF, 64'h80000000_00000000, 1};

    // Reset state of all three instances
    #12;
    for (int s = 0; s < 3; s++) begin
      sel = s; #1;
      check("reset_ctrl", s, 64'({o_ready, o_wr, o_wait}), 64'd0);
      check("reset_rd", s, o_rd, 64'd0);
    end
    @(negedge clk); resetn = 1'b1;

    for (int k = 0; k < NV; k++)
      run_op(vt[k].s, vt[k].i, vt[k].a, vt[k].b, vt[k].rd, vt[k].cyc, k);

    // Instructions that must not decode: MUL, and a W op on an instance without W support
    @(posedge clk); #1;
    sel = 0; insn = {7'b0000001, 10'd0, 3'b000, 5'd3, 7'b0110011}; rs1 = 64'd9; rs2 = 64'd3; valid = 1'b1;
    expect_silent(40, 100);
    valid = 1'b0;
    @(posedge clk); #1;
    insn = mk(F_DIV, 1); valid = 1'b1;
    expect_silent(40, 101);
    valid = 1'b0;

    // Reset in the middle of a RUN on the STEPS=4 instance
    run_op(1, mk(F_DIV, 0), 64'd1000, 64'hFFFFFFFD, 64'hFFFFFEB3, 9, 200);
    @(posedge clk); #1;
    sel = 1; insn = mk(F_DIV, 0); rs1 = 64'd500; rs2 = 64'd7; valid = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk); #1;
      if (c == 4) check("wait_before_reset", 201, 64'(o_wait), 64'd1);
    end
    resetn = 1'b0; #1;
    check("reset_mid_ctrl", 202, 64'({o_ready, o_wr, o_wait}), 64'd0);
    check("reset_mid_rd", 202, o_rd, 64'd0);
    @(posedge clk); #1;
    valid = 1'b0; resetn = 1'b1;
    expect_silent(12, 203);
    run_op(1, mk(F_DIV, 0), 64'd1000, 64'hFFFFFFFD, 64'hFFFFFEB3, 9, 204);
    run_op(1, mk(F_REM, 0), 64'd1000, 64'hFFFFFFFD, 64'd1, 1, 205);
    run_op(1, mk(F_DIV, 0), 64'd500, 64'd7, 64'd71, 9, 206);

    // Valid dropped at cycle 10 of a 64-bit RUN
    @(posedge clk); #1;
    sel = 2; insn = mk(F_DIVU, 0); rs1 = 64'h00001234_00000000; rs2 = 64'h1234; valid = 1'b1;
    for (int c = 1; c <= 10; c++) @(posedge clk);
    #1 valid = 1'b0;
    @(posedge clk); #1;
    check("abort_wait", 300, 64'(o_wait), 64'd0);
    expect_silent(70, 301);
    run_op(2, mk(F_DIVU, 0), 64'h00001234_00000000, 64'h1234, 64'h00000001_00000000, 65, 302);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog[0]: got timeout, required end of test");
    $fatal(1, "watchdog");
  end
endmodule
